stp_load_ctrl: RTL
==================

# stp_load_ctrl

Sequencing controller for the 48-entry, 16-bit serial-to-parallel shift register that assembles FFT input frames. It accepts a non-backpressured sample stream, drives the shift register's strobe and serial data, and counts exactly one frame of samples. It then holds the frame stable until the FFT core acknowledges capture. Samples arriving while the frame is held are dropped and counted as overruns.

## Interface
Parameters:
- NUM_SAMPLES, 48, samples per frame (≥2)
- DATA_W, 16, sample width
- OVR_W, 8, overrun counter width

Ports:
- clk  in  1  system clock (400 MHz)
- n_rst  in  1  reset; one clock, asynchronous, active-low
- enable  in  1  allow frame filling
- sample_valid  in  1  sample_in valid this cycle; no backpressure
- sample_in  in  DATA_W  incoming sample
- shift_strobe  out  1  drives the shift register's it_cnt_strobe
- serial_out  out  DATA_W  drives the shift register's serial_in
- frame_ready  out  1  all NUM_SAMPLES samples present in the register, stable
- fft_ack  in  1  FFT core has captured data_par
- fill_cnt  out  $clog2(NUM_SAMPLES+1)  samples accepted in the current frame
- overrun_cnt  out  OVR_W  dropped samples, saturating
- ovr_clr  in  1  synchronous clear of overrun_cnt

## Operation
- Reset values: state IDLE; shift_strobe 0; serial_out 0; frame_ready 0; fill_cnt 0; overrun_cnt 0.
- States: IDLE, FILL, HOLD.
- IDLE:
  - enable=1 → FILL.
  - Samples are ignored and not counted as overruns.
- FILL:
  - Accept when sample_valid=1: register shift_strobe<=1, serial_out<=sample_in, fill_cnt+1.
  - Accepting sample NUM_SAMPLES → HOLD on the same edge.
  - enable=0 with no accept in that cycle → IDLE; fill_cnt<=0. The partial frame is discarded and the register is not cleared; the next frame's NUM_SAMPLES shifts overwrite it completely.
  - enable=0 and sample_valid=1 in the same cycle → the sample is accepted, then go to IDLE with fill_cnt cleared.
- shift_strobe is high for exactly one cycle per accepted sample and is never high otherwise. serial_out holds its value when no sample is accepted.
- HOLD:
  - frame_ready rises the cycle after the final shift_strobe, so the last shift has landed first.
  - Every sample_valid in HOLD, including during the ack cycle, is dropped and increments overrun_cnt.
  - overrun_cnt saturates at 2^OVR_W−1.
  - ovr_clr wins over a simultaneous increment.
- Leaving HOLD:
  - Condition: fft_ack=1 while frame_ready=1.
  - Next cycle: frame_ready=0, fill_cnt=0, state FILL if enable=1, else IDLE.
  - fft_ack is ignored while frame_ready=0.
- enable=0 during HOLD does not release the frame; only fft_ack does.
- Reset mid-operation: all outputs return to reset values immediately (async). A partially filled frame is lost.

## Timing
- Sample accepted in cycle t:
  - shift_strobe/serial_out valid in t+1.
  - Shift register updates at the end of t+1.
- Final sample accepted in cycle t → frame_ready=1 from cycle t+2.
- Ack in cycle a:
  - frame_ready=0 in a+1.
  - First new sample can be accepted in a+1, strobed in a+2.
- Back-to-back sample_valid in FILL gives continuous strobes at one per cycle.
- Minimum frame period with continuous input and immediate ack: NUM_SAMPLES+2 cycles.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package stp_pkg holds:
  - state enum stp_state_e {IDLE, FILL, HOLD}
  - default constants STP_NUM_SAMPLES=48 and STP_DATA_W=16, also used by the shift register and the FFT core
- One sub-module: stp_sat_cnt, a parameterised saturating counter with inc and clr inputs, used for overrun_cnt.
- FSM, fill counter and output registers live in stp_load_ctrl.

## Test plan
- Reset, then enable=1 with 48 consecutive samples 0x0001..0x0030:
  - 48 single-cycle strobes, serial_out following the input.
  - frame_ready=1 two cycles after the last accept; the attached register holds 0x0030 at entry 47 and 0x0001 at entry 0.
- Frame held, 5 samples applied, no ack:
  - No strobes, overrun_cnt=5, frame_ready stays 1.
  - Pulse ovr_clr → 0.
- 300 samples during HOLD: overrun_cnt saturates at 255.
- enable dropped after 20 accepts: state IDLE, fill_cnt=0, no frame_ready. Re-enable with 48 samples → normal frame_ready.
- fft_ack with continuous sample_valid and enable=1:
  - The ack-cycle sample is dropped (+1 overrun).
  - The next sample is strobed 2 cycles after ack; frame_ready low one cycle after ack.
- n_rst asserted at fill_cnt=30: all outputs 0 asynchronously. After release, a full 48-sample frame is required before frame_ready.

Source files
------------

// File: rtl/stp_pkg.sv
// Shared types and default frame geometry for the serial-to-parallel FFT input path.
// Used by the load controller, the 48-entry shift register and the FFT core.
package stp_pkg;

  localparam int STP_NUM_SAMPLES = 48;
  localparam int STP_DATA_W      = 16;
  localparam int STP_OVR_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } stp_state_e;

endpackage

// File: rtl/stp_load_ctrl_if.sv
// Sample-stream, shift-register drive and FFT-handshake signals of the load controller.
// slave is the controller side; master is the sample source / FFT / shift-register side.
interface stp_load_ctrl_if
  import stp_pkg::*;
#(
  parameter int NUM_SAMPLES = STP_NUM_SAMPLES,
  parameter int DATA_W      = STP_DATA_W,
  parameter int OVR_W       = STP_OVR_W
) ();

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

  logic              enable;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              fft_ack;
  logic              ovr_clr;
  logic              shift_strobe;
  logic [DATA_W-1:0] serial_out;
  logic              frame_ready;
  logic [CNT_W-1:0]  fill_cnt;
  logic [OVR_W-1:0]  overrun_cnt;

  modport slave (
    input  enable, sample_valid, sample_in, fft_ack, ovr_clr,
    output shift_strobe, serial_out, frame_ready, fill_cnt, overrun_cnt
  );

  modport master (
    output enable, sample_valid, sample_in, fft_ack, ovr_clr,
    input  shift_strobe, serial_out, frame_ready, fill_cnt, overrun_cnt
  );

endinterface

// File: rtl/stp_sat_cnt.sv
// Saturating up-counter; clr beats inc. One-cycle registered update, no backpressure.
module stp_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/stp_load_ctrl.sv
// Fills the shift register with one frame, then holds it until fft_ack; strobe/data one cycle after accept.
// Input stream is never backpressured: samples arriving while a frame is held are dropped and counted.
module stp_load_ctrl
  import stp_pkg::*;
#(
  parameter int NUM_SAMPLES = STP_NUM_SAMPLES,
  parameter int DATA_W      = STP_DATA_W,
  parameter int OVR_W       = STP_OVR_W
) (
  input  logic                  clk,
  input  logic                  n_rst,
  stp_load_ctrl_if.slave        bus
);

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  stp_state_e        state_q,  state_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic              strobe_q, strobe_d;
  logic [DATA_W-1:0] serial_q, serial_d;
  logic              ready_q,  ready_d;
  logic              ovr_inc;
  logic [OVR_W-1:0]  ovr_cnt;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    strobe_d   = 1'b0;
    serial_d   = serial_q;
    ready_d    = ready_q;
    ovr_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.sample_valid) begin
          strobe_d   = 1'b1;
          serial_d   = bus.sample_in;
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
          // A completed frame is held even if enable falls on the final accept.
          if (fill_cnt_q == LAST_IDX) begin
            state_d = HOLD;
          end else if (!bus.enable) begin
            state_d    = IDLE;
            fill_cnt_d = '0;
          end
        end else if (!bus.enable) begin
          state_d    = IDLE;
          fill_cnt_d = '0;
        end
      end
      HOLD: begin
        ovr_inc = bus.sample_valid;
        // frame_ready lags HOLD entry by a cycle so the final shift has landed.
        if (ready_q && bus.fft_ack) begin
          ready_d    = 1'b0;
          fill_cnt_d = '0;
          state_d    = bus.enable ? FILL : IDLE;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        fill_cnt_d = '0;
        ready_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
      strobe_q   <= 1'b0;
      serial_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      strobe_q   <= strobe_d;
      serial_q   <= serial_d;
      ready_q    <= ready_d;
    end
  end

  stp_sat_cnt #(
    .W (OVR_W)
  ) u_ovr_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (ovr_inc),
    .clr   (bus.ovr_clr),
    .cnt   (ovr_cnt)
  );

  assign bus.shift_strobe = strobe_q;
  assign bus.serial_out   = serial_q;
  assign bus.frame_ready  = ready_q;
  assign bus.fill_cnt     = fill_cnt_q;
  assign bus.overrun_cnt  = ovr_cnt;

endmodule
